sram_ahb_arb: RTL and testbench

Two-port arbiter and AHB-Lite master sequencer that shares one `sramc_top` slave port between two internal requesters (A and B). It accepts simple valid/ready word, halfword or byte requests, grants them round-robin, and issues AHB SINGLE NONSEQ transfers. It returns read data and error status per requester. It sits directly in front of `sramc_top` and owns its `hsel`/`htrans`/`haddr`/`hwdata` inputs.

---
 rtl/sram_arb_pkg.sv | 43 ++++
 rtl/sram_rr_pick.sv | 33 +++
 rtl/sram_ahb_arb.sv | 232 +++++++++++++++++++++++
 tb/tb_sram_ahb_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and request legality check
// for the two-port SRAM arbiter.
package sram_arb_pkg;

  // AHB transfer type codes
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB transfer size codes (32-bit bus, word is the widest)
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // AHB response codes
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Only single transfers are ever issued
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } arb_state_e;

  // A request is legal when its size is byte/half/word and the address is
  // naturally aligned for that size.
  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr_lo[0];
      2'b10:   ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin picker. The priority bit flips to the port that was
// not granted whenever a grant is taken, so a lone requester always wins
// and two persistent requesters alternate.
module sram_rr_pick (
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_q;   // 0: port A favoured, 1: port B favoured
  logic prio_d;

  // One-hot grant from the request vector and current priority
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    prio_d = advance ? gnt[0] : prio_q;
  end

  // Priority register, A favoured out of reset
  always_ff @(posedge clk) begin
    if (srst) prio_q <= 1'b0;
    else      prio_q <= prio_d;
  end

endmodule

// File: rtl/sram_ahb_arb.sv
// Two-requester arbiter and AHB-Lite single-transfer sequencer in front of
// one SRAM slave port. One transfer is outstanding at a time; all bus and
// response outputs are registered alongside the state.
module sram_ahb_arb
  import sram_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 16
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          test_mode,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_write,
  input  logic [1:0]    a_size,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rsp_valid,
  output logic          a_rsp_err,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_write,
  input  logic [1:0]    b_size,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rsp_valid,
  output logic          b_rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic          hsel,
  output logic          hwrite,
  output logic [1:0]    htrans,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [AW-1:0] haddr,
  output logic [DW-1:0] hwdata,
  output logic          hready,
  input  logic          hready_resp,
  input  logic [1:0]    hresp,
  input  logic [DW-1:0] hrdata
);

  localparam int CW = $clog2(TMO + 1);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;        // 0: A, 1: B
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hsel_q, hsel_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic [DW-1:0] hwdata_q, hwdata_d;
  logic          a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
  logic          a_rsp_err_q, a_rsp_err_d, b_rsp_err_q, b_rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]    gnt;
  logic          grant_ok;
  logic          rsp_fire, rsp_err;
  logic          sel_write;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // New grants only from IDLE and only while no test mode is active
  assign grant_ok = (state_q == ST_IDLE) && !test_mode;

  sram_rr_pick u_pick (
    .clk     (hclk),
    .srst    (hreset),
    .req     ({b_valid, a_valid} & {2{grant_ok}}),
    .advance (|gnt),
    .gnt     (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  // Mux the winning requester's fields for capture
  always_comb begin
    sel_write = gnt[1] ? b_write : a_write;
    sel_size  = gnt[1] ? b_size  : a_size;
    sel_addr  = gnt[1] ? b_addr  : a_addr;
    sel_wdata = gnt[1] ? b_wdata : a_wdata;
  end

  // Next-state and next-output logic for the transfer sequencer
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    hsel_d      = 1'b0;
    htrans_d    = HTRANS_IDLE;
    hwrite_d    = 1'b0;
    hsize_d     = HSIZE_BYTE;
    haddr_d     = '0;
    hwdata_d    = '0;
    rsp_fire    = 1'b0;
    rsp_err     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          write_d = sel_write;
          size_d  = sel_size;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (req_legal(sel_size, sel_addr[1:0])) begin
            state_d  = ST_ADDR;
            hsel_d   = 1'b1;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = sel_write;
            hsize_d  = {1'b0, sel_size};
            haddr_d  = sel_addr;
          end else begin
            // Rejected without touching the bus
            state_d     = ST_RESP;
            rsp_fire    = 1'b1;
            rsp_err     = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ST_ADDR: begin
        if (hready_resp) begin
          state_d  = ST_DATA;
          cnt_d    = '0;
          hwdata_d = write_q ? wdata_q : '0;
        end else begin
          hsel_d   = 1'b1;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = write_q;
          hsize_d  = {1'b0, size_q};
          haddr_d  = addr_q;
        end
      end
      ST_DATA: begin
        if (hready_resp) begin
          state_d     = ST_RESP;
          rsp_fire    = 1'b1;
          rsp_err     = (hresp != HRESP_OKAY);
          rsp_rdata_d = (!write_q && hresp == HRESP_OKAY) ? hrdata : '0;
        end else if (cnt_q >= CW'(TMO - 1)) begin
          // This is the TMO-th stalled data cycle: give up
          state_d     = ST_RESP;
          cnt_d       = CW'(TMO);
          rsp_fire    = 1'b1;
          rsp_err     = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          hwdata_d = write_q ? wdata_q : '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    a_rsp_valid_d = rsp_fire & ~owner_d;
    b_rsp_valid_d = rsp_fire &  owner_d;
    a_rsp_err_d   = rsp_fire & rsp_err & ~owner_d;
    b_rsp_err_d   = rsp_fire & rsp_err &  owner_d;
  end

  // State, captured request and registered outputs
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      hsel_q        <= 1'b0;
      htrans_q      <= HTRANS_IDLE;
      hwrite_q      <= 1'b0;
      hsize_q       <= HSIZE_BYTE;
      haddr_q       <= '0;
      hwdata_q      <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_err_q   <= 1'b0;
      b_rsp_err_q   <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      write_q       <= write_d;
      size_q        <= size_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      hsel_q        <= hsel_d;
      htrans_q      <= htrans_d;
      hwrite_q      <= hwrite_d;
      hsize_q       <= hsize_d;
      haddr_q       <= haddr_d;
      hwdata_q      <= hwdata_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rsp_err_q   <= a_rsp_err_d;
      b_rsp_err_q   <= b_rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign hsel        = hsel_q;
  assign htrans      = htrans_q;
  assign hwrite      = hwrite_q;
  assign hsize       = hsize_q;
  assign hburst      = HBURST_SINGLE;
  assign haddr       = haddr_q;
  assign hwdata      = hwdata_q;
  assign hready      = hready_resp;
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_err   = a_rsp_err_q;
  assign b_rsp_err   = b_rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_sram_ahb_arb.sv
// Directed bench for sram_ahb_arb with a small behavioural AHB SRAM slave.
module tb_sram_ahb_arb;
  localparam int AW = 32, DW = 32, TMO = 16;

  logic hclk = 1'b0;
  logic hreset, test_mode;
  logic a_valid, a_ready, a_write, a_rsp_valid, a_rsp_err;
  logic b_valid, b_ready, b_write, b_rsp_valid, b_rsp_err;
  logic [1:0] a_size, b_size;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, rsp_rdata;
  logic hsel, hwrite, hready, hready_resp;
  logic [1:0] htrans, hresp;
  logic [2:0] hsize, hburst;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata, hrdata;

  int checks = 0, errors = 0;

  always #5 hclk = ~hclk;

  sram_ahb_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .hclk(hclk), .hreset(hreset), .test_mode(test_mode),
    .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_size(a_size),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rsp_err(a_rsp_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_size(b_size),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rsp_err(b_rsp_err),
    .rsp_rdata(rsp_rdata), .hsel(hsel), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .haddr(haddr), .hwdata(hwdata), .hready(hready),
    .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata)
  );

  // ---------------- behavioural slave ----------------
  logic [31:0] mem [0:63];
  logic        dphase = 1'b0, dwrite = 1'b0;
  logic [31:0] daddr = '0;
  logic [2:0]  dsize = '0;
  int          wcnt = 0, wait_n = 0;
  bit          slv_err = 0;

  assign hready_resp = !(dphase && (wcnt < wait_n));
  assign hresp       = (dphase && hready_resp && slv_err) ? 2'b01 : 2'b00;
  assign hrdata      = (dphase && !dwrite) ? mem[daddr[7:2]] : 32'h0;

  always @(posedge hclk) begin
    if (hreset) begin
      dphase <= 1'b0;
      wcnt   <= 0;
    end else begin
      if (dphase && hready_resp && dwrite && !slv_err) begin
        for (int l = 0; l < 4; l++) begin
          if ((dsize == 3'd2) || (dsize == 3'd1 && (l / 2) == int'(daddr[1])) ||
              (dsize == 3'd0 && l == int'(daddr[1:0])))
            mem[daddr[7:2]][8*l +: 8] <= hwdata[8*l +: 8];
        end
      end
      if (hsel && htrans == 2'b10 && hready_resp) begin
        dphase <= 1'b1; dwrite <= hwrite; daddr <= haddr; dsize <= hsize; wcnt <= 0;
      end else if (dphase && hready_resp) begin
        dphase <= 1'b0;
      end else if (dphase) begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // ---------------- activity monitor ----------------
  int a_rsp_cnt = 0, b_rsp_cnt = 0, bus_cnt = 0;
  logic [2:0] last_hsize = '0;
  always @(posedge hclk) begin
    if (a_rsp_valid) a_rsp_cnt <= a_rsp_cnt + 1;
    if (b_rsp_valid) b_rsp_cnt <= b_rsp_cnt + 1;
    if (hsel && htrans == 2'b10 && hready_resp) begin
      bus_cnt    <= bus_cnt + 1;
      last_hsize <= hsize;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Walks negedges from cycle 1 until the port's rsp_valid is seen
  task automatic wait_rsp(input bit port, output int lat, output logic er,
                          output logic [31:0] rd, output bit got);
    got = 0; lat = 1; er = 0; rd = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (port ? b_rsp_valid : a_rsp_valid) begin
        got = 1; er = port ? b_rsp_err : a_rsp_err; rd = rsp_rdata;
      end else begin
        @(negedge hclk); lat++;
      end
    end
  endtask

  typedef struct {
    bit          port;   // 0 A, 1 B
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;     // stalled data cycles from the slave
    bit          se;     // slave returns ERROR
    bit          e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_bus;
  } vec_t;

  task automatic run_req(input int idx, input vec_t v);
    int lat, ac0, bc0, bus0;
    logic er;
    logic [31:0] rd;
    bit got;
    wait_n = v.wt; slv_err = v.se;
    ac0 = a_rsp_cnt; bc0 = b_rsp_cnt; bus0 = bus_cnt;
    @(negedge hclk);
    if (v.port) begin
      b_valid = 1; b_write = v.wr; b_size = v.sz; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_valid = 1; a_write = v.wr; a_size = v.sz; a_addr = v.addr; a_wdata = v.wdata;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (v.port ? b_ready : a_ready) got = 1;
      else @(negedge hclk);
    end
    chk($sformatf("v%0d accept", idx), 32'(got), 32'd1);
    @(negedge hclk);
    a_valid = 0; b_valid = 0;
    wait_rsp(v.port, lat, er, rd, got);
    chk($sformatf("v%0d rsp_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.e_lat));
    chk($sformatf("v%0d err", idx), 32'(er), 32'(v.e_err));
    chk($sformatf("v%0d rdata", idx), rd, v.e_rdata);
    @(negedge hclk);
    chk($sformatf("v%0d idle_htrans", idx), 32'(htrans), 32'd0);
    chk($sformatf("v%0d own_pulses", idx),
        32'(v.port ? b_rsp_cnt - bc0 : a_rsp_cnt - ac0), 32'd1);
    chk($sformatf("v%0d other_pulses", idx),
        32'(v.port ? a_rsp_cnt - ac0 : b_rsp_cnt - bc0), 32'd0);
    chk($sformatf("v%0d bus_xfers", idx), 32'(bus_cnt - bus0), 32'(v.e_bus));
    if (v.e_bus != 0) chk($sformatf("v%0d hsize", idx), 32'(last_hsize), {29'd0, 1'b0, v.sz});
    $display("txn v%0d port=%s wr=%0d size=%0d addr=%h lat=%0d err=%0d rdata=%h",
             idx, v.port ? "B" : "A", v.wr, v.sz, v.addr, lat, er, rd);
  endtask

  vec_t vecs [12];

  initial begin
    int order [3];
    int gcyc [3];
    int ngr, cnt, rc, lat;
    logic er;
    logic [31:0] rd;
    bit got;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    //          port wr sz    addr          wdata         wt   se err rdata         lat bus
    vecs[0]  = '{0, 1, 2'd2, 32'h0000_0004, 32'h0001_23AF, 0,    0, 0, 32'h0,         3,  1};
    vecs[1]  = '{0, 0, 2'd2, 32'h0000_0004, 32'h0,         0,    0, 0, 32'h0001_23AF, 3,  1};
    vecs[2]  = '{1, 0, 2'd2, 32'h0000_0099, 32'h0,         0,    0, 1, 32'h0,         1,  0};
    vecs[3]  = '{1, 1, 2'd3, 32'h0000_0040, 32'h1234_5678, 0,    0, 1, 32'h0,         1,  0};
    vecs[4]  = '{1, 1, 2'd1, 32'h0000_0008, 32'h0000_BEEF, 0,    0, 0, 32'h0,         3,  1};
    vecs[5]  = '{0, 1, 2'd0, 32'h0000_000B, 32'hC300_0000, 0,    0, 0, 32'h0,         3,  1};
    vecs[6]  = '{0, 0, 2'd2, 32'h0000_0008, 32'h0,         3,    0, 0, 32'hC300_BEEF, 6,  1};
    vecs[7]  = '{1, 0, 2'd1, 32'h0000_0003, 32'h0,         0,    0, 1, 32'h0,         1,  0};
    vecs[8]  = '{0, 0, 2'd2, 32'h0000_0004, 32'h0,         0,    1, 1, 32'h0,         3,  1};
    vecs[9]  = '{1, 0, 2'd0, 32'h0000_0008, 32'h0,         0,    0, 0, 32'hC300_BEEF, 3,  1};
    vecs[10] = '{0, 0, 2'd2, 32'h0000_0000, 32'h0,         1000, 0, 1, 32'h0,         18, 1};
    vecs[11] = '{0, 0, 2'd2, 32'h0000_0004, 32'h0,         0,    0, 0, 32'h0001_23AF, 3,  1};

    hreset = 1; test_mode = 0;
    a_valid = 0; a_write = 0; a_size = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_write = 0; b_size = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(negedge hclk);
    hreset = 0;

    // Reset state
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hsel", 32'(hsel), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    chk("rst_rsp_err", {30'd0, a_rsp_err, b_rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
    $display("txn reset checked");

    // Simultaneous requesters: A, B, A at 4-cycle spacing
    a_valid = 1; a_write = 0; a_size = 2; a_addr = 32'h10;
    b_valid = 1; b_write = 0; b_size = 2; b_addr = 32'h20;
    ngr = 0;
    for (int k = 0; k < 40 && ngr < 3; k++) begin
      #1;
      if (a_ready && b_ready) chk("sim_both_ready", 32'd1, 32'd0);
      if (a_ready) begin order[ngr] = 0; gcyc[ngr] = k; ngr++; end
      else if (b_ready) begin order[ngr] = 1; gcyc[ngr] = k; ngr++; end
      @(negedge hclk);
    end
    a_valid = 0; b_valid = 0;
    chk("sim_grants", 32'(ngr), 32'd3);
    chk("sim_order0", 32'(order[0]), 32'd0);
    chk("sim_order1", 32'(order[1]), 32'd1);
    chk("sim_order2", 32'(order[2]), 32'd0);
    chk("sim_gap1", 32'(gcyc[1] - gcyc[0]), 32'd4);
    chk("sim_gap2", 32'(gcyc[2] - gcyc[1]), 32'd4);
    wait_rsp(0, lat, er, rd, got);
    chk("sim_last_rsp", 32'(got), 32'd1);
    @(negedge hclk);
    $display("txn simultaneous order=%0d%0d%0d cycles=%0d,%0d,%0d",
             order[0], order[1], order[2], gcyc[0], gcyc[1], gcyc[2]);

    for (int i = 0; i < 12; i++) run_req(i, vecs[i]);

    // test_mode raised during DATA of an A write; B blocked until it drops
    wait_n = 0; slv_err = 0;
    @(negedge hclk);
    a_valid = 1; a_write = 1; a_size = 2; a_addr = 32'h30; a_wdata = 32'h5A5A_5A5A;
    #1 chk("tm_a_ready", 32'(a_ready), 32'd1);
    @(negedge hclk);
    a_valid = 0;
    b_valid = 1; b_write = 0; b_size = 2; b_addr = 32'h30;
    #1 chk("tm_b_wait_busy", 32'(b_ready), 32'd0);
    @(negedge hclk);
    test_mode = 1;
    @(negedge hclk);
    chk("tm_a_rsp", {30'd0, a_rsp_valid, a_rsp_err}, 32'd2);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge hclk); #1;
      if (b_ready) cnt++;
    end
    chk("tm_b_blocked", 32'(cnt), 32'd0);
    @(negedge hclk);
    test_mode = 0;
    #1 chk("tm_b_ready", 32'(b_ready), 32'd1);
    @(negedge hclk);
    b_valid = 0;
    wait_rsp(1, lat, er, rd, got);
    chk("tm_b_rsp", 32'(got), 32'd1);
    chk("tm_b_rdata", rd, 32'h5A5A_5A5A);
    @(negedge hclk);
    $display("txn test_mode write/read rdata=%h", rd);

    // Reset pulsed while in ADDR
    @(negedge hclk);
    a_valid = 1; a_write = 0; a_size = 2; a_addr = 32'h4;
    #1 chk("rst_mid_accept", 32'(a_ready), 32'd1);
    @(negedge hclk);
    a_valid = 0;
    chk("rst_mid_addr", {29'd0, hsel, htrans}, 32'h6);
    hreset = 1;
    @(negedge hclk);
    hreset = 0;
    chk("rst_mid_htrans", 32'(htrans), 32'd0);
    chk("rst_mid_hsel", 32'(hsel), 32'd0);
    rc = a_rsp_cnt + b_rsp_cnt;
    repeat (6) @(negedge hclk);
    chk("rst_mid_no_rsp", 32'(a_rsp_cnt + b_rsp_cnt - rc), 32'd0);
    a_valid = 1; b_valid = 1; b_write = 0; b_size = 2; b_addr = 32'h20;
    #1 chk("rst_mid_prio", {30'd0, a_ready, b_ready}, 32'd2);
    @(negedge hclk);
    a_valid = 0; b_valid = 0;
    wait_rsp(0, lat, er, rd, got);
    chk("rst_mid_after_rdata", rd, 32'h0001_23AF);
    @(negedge hclk);
    $display("txn reset mid-ADDR then A read rdata=%h", rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
